uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter:
// FSM state encoding and the default stall watchdog length.
package uart_tx_arbiter_pkg;

   localparam int CLOCK_RATE       = 24000000;
   localparam int STALL_CYCLES_DEF = CLOCK_RATE / 100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req
// starting at ptr+1 and wrapping, plus an any-valid flag.
module uart_tx_arbiter_rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate back so the nearest one wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter in front of one UART
// transmitter, with a watchdog for sources that stall mid-message.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int DW           = 8,
   parameter int STALL_CYCLES = STALL_CYCLES_DEF,
   parameter int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    req_ready,
   output logic               tx_valid,
   output logic [DW-1:0]      tx_data,
   input  logic               tx_ready,
   output logic               busy,
   output logic [IDW-1:0]     grant_id,
   output logic               stall_err,
   output logic [IDW-1:0]     stall_id
);

   localparam int            CW       = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STALL_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_CYCLES);

   arb_state_t     state;
   logic [IDW-1:0] rr_ptr;
   logic [CW-1:0]  stall_cnt;
   logic [IDW-1:0] pick_idx;
   logic           pick_any;
   logic [DW-1:0]  data_arr [NREQ];
   logic [DW-1:0]  sel_data;
   logic           sel_valid;
   logic           sel_last;
   logic           tx_free;
   logic           hs;

   uart_tx_arbiter_rr_pick #(
      .N  (NREQ),
      .IW (IDW)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = req_data[i*DW +: DW];
      end
   end

   assign sel_data  = data_arr[grant_id];
   assign sel_valid = req_valid[grant_id];
   assign sel_last  = req_last[grant_id];

   // The output register frees up in the same cycle it is drained.
   assign tx_free = !tx_valid || tx_ready;
   assign hs      = (state == ST_LOCK) && sel_valid && tx_free;
   assign busy    = (state == ST_LOCK) || tx_valid;

   always_comb begin
      req_ready = '0;
      if (state == ST_LOCK) begin
         req_ready[grant_id] = tx_free;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         grant_id  <= '0;
         rr_ptr    <= IDW'(NREQ - 1);
         stall_cnt <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         stall_err <= 1'b0;
         stall_id  <= '0;
      end else begin
         stall_err <= 1'b0;
         if (hs) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data;
         end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state     <= ST_LOCK;
                  grant_id  <= pick_idx;
                  stall_cnt <= '0;
               end
            end
            ST_LOCK: begin
               if (hs) begin
                  stall_cnt <= '0;
                  if (sel_last) begin
                     state  <= ST_IDLE;
                     rr_ptr <= grant_id;
                  end
               end else if (!sel_valid) begin
                  // Backpressured-but-valid cycles never reach here.
                  if (stall_cnt == CNT_LAST) begin
                     state     <= ST_IDLE;
                     stall_err <= 1'b1;
                     stall_id  <= grant_id;
                     rr_ptr    <= grant_id;
                     stall_cnt <= CNT_MAX;
                  end else if (stall_cnt != CNT_MAX) begin
                     stall_cnt <= stall_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: sources replay byte tables, transfers are
// logged on the falling edge and compared with hand-computed orders.
module tb_uart_tx_arbiter;

   localparam int NREQ  = 3;
   localparam int DW    = 8;
   localparam int STALL = 16;
   localparam int IDW   = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic [NREQ-1:0]    req_last = '0;
   logic [NREQ-1:0]    req_ready;
   logic               tx_valid;
   logic [DW-1:0]      tx_data;
   logic               tx_ready = 1'b1;
   logic               busy;
   logic [IDW-1:0]     grant_id;
   logic               stall_err;
   logic [IDW-1:0]     stall_id;

   uart_tx_arbiter #(
      .NREQ         (NREQ),
      .DW           (DW),
      .STALL_CYCLES (STALL),
      .IDW          (IDW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .grant_id  (grant_id),
      .stall_err (stall_err),
      .stall_id  (stall_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] mem [NREQ][256];
   int len [NREQ];
   int pos [NREQ];
   bit hs_d [NREQ];
   int tx_mode = 0;
   int flush_gen = 0;
   int flush_seen = 0;

   // Source and sink driver, 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (flush_gen != flush_seen) pos[i] = len[i];
         else if (hs_d[i]) pos[i] = pos[i] + 1;
         if (pos[i] < len[i]) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = mem[i][8'(pos[i])][7:0];
            req_last[i] = mem[i][8'(pos[i])][8];
         end else begin
            req_valid[i] = 1'b0;
            req_data[i*DW +: DW] = '0;
            req_last[i] = 1'b0;
         end
      end
      flush_seen = flush_gen;
      case (tx_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = (cyc % 3) != 2;
         default: tx_ready = 1'b0;
      endcase
   end

   int hs_src[$];
   int hs_byte[$];
   int hs_cyc[$];
   int tx_byte[$];
   int tx_cyc[$];
   int st_cyc[$];
   int st_id[$];
   int bp_viol = 0;
   int busy_fall = -1;
   bit busy_prev = 1'b0;

   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         hs_d[i] = rst_n && req_valid[i] && req_ready[i];
         if (hs_d[i]) begin
            hs_src.push_back(i);
            hs_byte.push_back(int'(req_data[i*DW +: DW]));
            hs_cyc.push_back(cyc);
         end
      end
      if (rst_n && tx_valid && tx_ready) begin
         tx_byte.push_back(int'(tx_data));
         tx_cyc.push_back(cyc);
      end
      if (rst_n && stall_err) begin
         st_cyc.push_back(cyc);
         st_id.push_back(int'(stall_id));
      end
      if (tx_valid && !tx_ready && req_ready != '0) bp_viol++;
      if (busy_prev && !busy) busy_fall = cyc;
      busy_prev = busy;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic put(input int s, input logic [7:0] b, input logic l);
      mem[s][8'(len[s])] = {l, b};
      len[s] = len[s] + 1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         step();
         ok = !busy;
         for (int i = 0; i < NREQ; i++) if (pos[i] < len[i]) ok = 1'b0;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush_gen++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({req_ready, tx_valid, busy, stall_err} !== '0) begin
         failures++;
         $display("FAIL rst_flags got=%b exp=0", {req_ready, tx_valid, busy, stall_err});
      end
      checks++;
      if (tx_data !== 8'h00) begin
         failures++;
         $display("FAIL rst_tx_data got=%h exp=00", tx_data);
      end
      checks++;
      if ({grant_id, stall_id} !== 4'h0) begin
         failures++;
         $display("FAIL rst_ids got=%h exp=0", {grant_id, stall_id});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if ({busy, req_ready} !== '0) begin
         failures++;
         $display("FAIL post_rst_idle got=%b exp=0", {busy, req_ready});
      end
   endtask

   task automatic test_single();
      int hb, tb, sb;
      bit ok;
      logic [7:0] e [4];
      e = '{8'h1B, 8'h5B, 8'h3B, 8'h48};
      hb = hs_src.size();
      tb = tx_byte.size();
      sb = st_cyc.size();
      for (int k = 0; k < 4; k++) put(0, e[k], k == 3);
      wait_done(40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_timeout got=busy exp=done");
      end
      checks++;
      if (tx_byte.size() - tb !== 4) begin
         failures++;
         $display("FAIL single_count got=%0d exp=4", tx_byte.size() - tb);
      end
      if (tx_byte.size() >= tb + 4 && hs_cyc.size() >= hb + 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_byte[tb+k] !== int'(e[k])) begin
               failures++;
               $display("FAIL single_byte%0d got=%h exp=%h", k, tx_byte[tb+k], e[k]);
            end
            checks++;
            if (tx_cyc[tb+k] !== hs_cyc[hb+k] + 1) begin
               failures++;
               $display("FAIL single_lat%0d got=%0d exp=%0d", k, tx_cyc[tb+k], hs_cyc[hb+k] + 1);
            end
            if (k > 0) begin
               checks++;
               if (tx_cyc[tb+k] !== tx_cyc[tb+k-1] + 1) begin
                  failures++;
                  $display("FAIL single_rate%0d got=%0d exp=%0d", k, tx_cyc[tb+k], tx_cyc[tb+k-1] + 1);
               end
            end
         end
         checks++;
         if (busy_fall !== tx_cyc[tb+3] + 1) begin
            failures++;
            $display("FAIL single_busy_fall got=%0d exp=%0d", busy_fall, tx_cyc[tb+3] + 1);
         end
      end
      checks++;
      if (st_cyc.size() !== sb) begin
         failures++;
         $display("FAIL single_stall got=%0d exp=%0d", st_cyc.size(), sb);
      end
   endtask

   task automatic test_two_sources();
      int hb, tb;
      bit ok;
      int es [6];
      int eb [6];
      es = '{0, 0, 0, 2, 2, 2};
      eb = '{'hA0, 'hA1, 'hA2, 'hC0, 'hC1, 'hC2};
      do_reset();
      hb = hs_src.size();
      tb = tx_byte.size();
      for (int k = 0; k < 3; k++) put(0, 8'(eb[k]), k == 2);
      for (int k = 3; k < 6; k++) put(2, 8'(eb[k]), k == 5);
      wait_done(60, ok);
      checks++;
      if (!ok || hs_src.size() - hb !== 6 || tx_byte.size() - tb !== 6) begin
         failures++;
         $display("FAIL two_count got=%0d/%0d exp=6", hs_src.size() - hb, tx_byte.size() - tb);
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (hs_src[hb+k] !== es[k] || tx_byte[tb+k] !== eb[k]) begin
               failures++;
               $display("FAIL two_order%0d got=%0d:%h exp=%0d:%h", k, hs_src[hb+k], tx_byte[tb+k], es[k], eb[k]);
            end
         end
         checks++;
         if (hs_cyc[hb+3] - hs_cyc[hb+2] !== 2) begin
            failures++;
            $display("FAIL two_dead_cycle got=%0d exp=2", hs_cyc[hb+3] - hs_cyc[hb+2]);
         end
      end
   endtask

   task automatic test_round_robin();
      int hb;
      bit ok;
      int es [6];
      es = '{0, 1, 2, 0, 1, 2};
      hb = hs_src.size();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NREQ; s++) put(s, 8'(16 * (s + 1) + r), 1'b1);
      wait_done(60, ok);
      checks++;
      if (!ok || hs_src.size() - hb !== 6) begin
         failures++;
         $display("FAIL rr_count got=%0d exp=6", hs_src.size() - hb);
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (hs_src[hb+k] !== es[k] || hs_byte[hb+k] !== 16 * (es[k] + 1) + k / 3) begin
               failures++;
               $display("FAIL rr_grant%0d got=%0d:%h exp=%0d:%h", k, hs_src[hb+k], hs_byte[hb+k], es[k], 16 * (es[k] + 1) + k / 3);
            end
            if (k > 0) begin
               checks++;
               if (hs_cyc[hb+k] - hs_cyc[hb+k-1] !== 2) begin
                  failures++;
                  $display("FAIL rr_gap%0d got=%0d exp=2", k, hs_cyc[hb+k] - hs_cyc[hb+k-1]);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int tb, bv, bad;
      bit ok;
      tx_mode = 1;
      step();
      tb = tx_byte.size();
      bv = bp_viol;
      bad = 0;
      for (int k = 0; k < 64; k++) put(1, 8'(5 * k + 3), k == 63);
      wait_done(400, ok);
      checks++;
      if (!ok || tx_byte.size() - tb !== 64) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=64", tx_byte.size() - tb);
      end else begin
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (tx_byte[tb+k] !== (5 * k + 3) % 256) begin
               failures++;
               $display("FAIL bp_byte%0d got=%h exp=%h", k, tx_byte[tb+k], (5 * k + 3) % 256);
            end
         end
      end
      checks++;
      if (bp_viol !== bv) begin
         failures++;
         $display("FAIL bp_ready_when_full got=%0d exp=0", bp_viol - bv);
      end
      tx_mode = 0;
      step();
   endtask

   task automatic test_stall();
      int hb, tb, sb;
      bit ok;
      hb = hs_src.size();
      tb = tx_byte.size();
      sb = st_cyc.size();
      put(1, 8'h41, 1'b0);
      put(1, 8'h42, 1'b0);
      for (int n = 0; n < 20 && pos[1] < len[1]; n++) step();
      put(0, 8'h55, 1'b1);
      for (int n = 0; n < 60 && st_cyc.size() == sb; n++) step();
      wait_done(40, ok);
      checks++;
      if (!ok || st_cyc.size() - sb !== 1 || hs_src.size() - hb !== 3) begin
         failures++;
         $display("FAIL stall_events got=%0d/%0d exp=1/3", st_cyc.size() - sb, hs_src.size() - hb);
      end else begin
         checks++;
         if (st_id[sb] !== 1) begin
            failures++;
            $display("FAIL stall_id got=%0d exp=1", st_id[sb]);
         end
         checks++;
         if (st_cyc[sb] !== hs_cyc[hb+1] + STALL + 1) begin
            failures++;
            $display("FAIL stall_time got=%0d exp=%0d", st_cyc[sb], hs_cyc[hb+1] + STALL + 1);
         end
         checks++;
         if (hs_src[hb+2] !== 0 || hs_cyc[hb+2] !== st_cyc[sb] + 1) begin
            failures++;
            $display("FAIL stall_next_grant got=%0d@%0d exp=0@%0d", hs_src[hb+2], hs_cyc[hb+2], st_cyc[sb] + 1);
         end
      end
      checks++;
      if (tx_byte.size() - tb !== 3 || tx_byte[tb] !== 'h41 || tx_byte[tb+1] !== 'h42 || tx_byte[tb+2] !== 'h55) begin
         failures++;
         $display("FAIL stall_tx got=%0d bytes exp=41,42,55", tx_byte.size() - tb);
      end
      checks++;
      if (stall_id !== 2'd1 || stall_err !== 1'b0) begin
         failures++;
         $display("FAIL stall_hold got=%0d/%b exp=1/0", stall_id, stall_err);
      end
   endtask

   task automatic test_reset_mid();
      int hb, tb;
      bit ok;
      tx_mode = 2;
      step();
      for (int k = 0; k < 10; k++) put(2, 8'(8'h80 + k), k == 9);
      for (int n = 0; n < 20 && tx_valid !== 1'b1; n++) step();
      checks++;
      if (tx_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pending got=%b exp=1", tx_valid);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_valid, busy, req_ready} !== '0) begin
         failures++;
         $display("FAIL mid_async_clear got=%b exp=0", {tx_valid, busy, req_ready});
      end
      flush_gen++;
      tx_mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hb = hs_src.size();
      tb = tx_byte.size();
      step();
      put(2, 8'h72, 1'b1);
      put(1, 8'h71, 1'b1);
      put(0, 8'h70, 1'b1);
      wait_done(40, ok);
      checks++;
      if (!ok || tx_byte.size() - tb !== 3 || hs_src.size() - hb !== 3) begin
         failures++;
         $display("FAIL mid_count got=%0d exp=3", tx_byte.size() - tb);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (hs_src[hb+k] !== k || tx_byte[tb+k] !== 'h70 + k) begin
               failures++;
               $display("FAIL mid_order%0d got=%0d:%h exp=%0d:%h", k, hs_src[hb+k], tx_byte[tb+k], k, 'h70 + k);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_sources();
      test_round_robin();
      test_backpressure();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
